// File: rtl/intan_spi_pkg.sv
// Shared constants for the Intan SPI master: opcodes, aux command table, FSM states, slot timing.
package intan_spi_pkg;

  localparam logic [4:0] LOCK_COUNT   = 5'd16;
  localparam int         NUM_CHANNELS = 35;
  localparam int         SCLK_DIV     = 4;
  localparam logic [6:0] SLOT_LAST    = 7'd79;
  localparam logic [6:0] SPI_CYCLES   = 7'd64;
  localparam logic [5:0] CH_LAST      = 6'd34;
  localparam logic [5:0] NUM_CONVERT  = 6'd32;

  localparam logic [1:0]  OP_CONVERT = 2'b00;
  localparam logic [15:0] AUX_CMD_0  = 16'hE800;
  localparam logic [15:0] AUX_CMD_1  = 16'hE900;
  localparam logic [15:0] AUX_CMD_2  = 16'hEA00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Slots 0..31 convert their own channel; 32..34 read the three aux registers.
  function automatic logic [15:0] cmd_for(input logic [5:0] ch);
    logic [15:0] cmd;
    cmd = {OP_CONVERT, ch, 8'h00};
    if (ch >= NUM_CONVERT) begin
      case (ch)
        6'd32:   cmd = AUX_CMD_0;
        6'd33:   cmd = AUX_CMD_1;
        default: cmd = AUX_CMD_2;
      endcase
    end
    return cmd;
  endfunction

endpackage

// File: rtl/intan_spi_clk_lock_gen.sv
// Lock indication: saturating counter after reset release; clk_stable rises on the
// LOCK_COUNT-th clock and stays high until the next reset.
module clk_lock_gen
  import intan_spi_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  output logic clk_stable_o
);

  logic [4:0] lock_cnt_q, lock_cnt_d;
  logic       stable_q;

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (lock_cnt_q != LOCK_COUNT) lock_cnt_d = lock_cnt_q + 5'd1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lock_cnt_q <= 5'd0;
      stable_q   <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      stable_q   <= (lock_cnt_d == LOCK_COUNT);
    end
  end

  assign clk_stable_o = stable_q;

endmodule

// File: rtl/intan_spi_top_module.sv
// Intan RHD2000-style SPI master: 35 command slots per frame, 80 clocks per slot,
// one-shot (max_timestep frames) or continuous; SPI pins registered from next-state.
module intan_spi_top_module
  import intan_spi_pkg::*;
(
  input  logic        clk_ext,
  input  logic        reset,
  input  logic        SPI_continuous,
  input  logic        SPI_start,
  input  logic [31:0] max_timestep,
  output logic        clk,
  output logic        clk_stable,
  output logic        SCLK,
  output logic        CS,
  output logic        MOSI,
  output logic [6:0]  state_counter,
  output logic [5:0]  channel,
  output logic [31:0] timestamp,
  output logic [3:0]  instr_counter,
  output logic [15:0] instr
);

  assign clk = clk_ext;

  clk_lock_gen u_lock (
    .clk_i        (clk_ext),
    .reset_i      (reset),
    .clk_stable_o (clk_stable)
  );

  state_e      state_q, state_d;
  logic [6:0]  sc_q, sc_d;
  logic [5:0]  ch_q, ch_d;
  logic [31:0] ts_q, ts_d;
  logic [3:0]  ic_q, ic_d;
  logic [15:0] instr_q, instr_d;
  logic        sclk_q, sclk_d;
  logic        cs_q, cs_d;
  logic        mosi_q, mosi_d;

  logic        slot_end, frame_end, zero_run, in_spi;
  logic [31:0] ts_inc;
  logic [3:0]  bit_idx;

  assign slot_end  = (sc_q == SLOT_LAST);
  assign frame_end = slot_end && (ch_q == CH_LAST);
  assign zero_run  = !SPI_continuous && (max_timestep == 32'd0);
  assign ts_inc    = ts_q + 32'd1;

  always_ff @(posedge clk_ext) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sc_q    <= 7'd0;
      ch_q    <= 6'd0;
      ts_q    <= 32'd0;
      ic_q    <= 4'd0;
      instr_q <= 16'd0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      ch_q    <= ch_d;
      ts_q    <= ts_d;
      ic_q    <= ic_d;
      instr_q <= instr_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
    end
  end

  // SPI_continuous only matters at a frame boundary, so a mid-run change waits for it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (clk_stable && SPI_start) state_d = zero_run ? ST_DONE : ST_RUN;
      ST_RUN:  if (frame_end && !SPI_continuous && (ts_inc == max_timestep)) state_d = ST_DONE;
      ST_DONE: if (!SPI_start) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sc_d = sc_q;
    ch_d = ch_q;
    ts_d = ts_q;
    if (state_q == ST_IDLE && state_d == ST_RUN) begin
      sc_d = 7'd0;
      ch_d = 6'd0;
      ts_d = 32'd0;
    end else if (state_q == ST_RUN) begin
      sc_d = slot_end ? 7'd0 : sc_q + 7'd1;
      if (slot_end)  ch_d = (ch_q == CH_LAST) ? 6'd0 : ch_q + 6'd1;
      if (frame_end) ts_d = ts_inc;
    end
    if (state_d != ST_RUN) sc_d = 7'd0;

    // Pins are decoded from the next counter value so they line up with state_counter.
    in_spi  = (state_d == ST_RUN) && (sc_d < SPI_CYCLES);
    bit_idx = sc_d[5:2];
    instr_d = cmd_for(ch_d);
    cs_d    = !in_spi;
    sclk_d  = in_spi && sc_d[1];
    ic_d    = in_spi ? bit_idx : 4'd0;
    mosi_d  = in_spi && instr_d[4'd15 - bit_idx];
  end

  assign state_counter = sc_q;
  assign channel       = ch_q;
  assign timestamp     = ts_q;
  assign instr_counter = ic_q;
  assign instr         = instr_q;
  assign SCLK          = sclk_q;
  assign CS            = cs_q;
  assign MOSI          = mosi_q;

endmodule

// File: tb/tb_intan_spi_top_module.sv
// Scoreboard bench for intan_spi_top_module: a pin monitor reassembles SPI words,
// tasks push expected commands and compare against what the monitor collected.
module tb_intan_spi_top_module;

  logic        clk_ext = 1'b0;
  logic        reset;
  logic        SPI_continuous;
  logic        SPI_start;
  logic [31:0] max_timestep;
  logic        clk, clk_stable, SCLK, CS, MOSI;
  logic [6:0]  state_counter;
  logic [5:0]  channel;
  logic [31:0] timestamp;
  logic [3:0]  instr_counter;
  logic [15:0] instr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  int          lo_q[$];
  int          ck_q[$];
  int          hi_q[$];

  logic        prev_cs   = 1'b1;
  logic        prev_sclk = 1'b0;
  logic [15:0] shreg     = 16'd0;
  int          lo_cnt = 0, hi_cnt = 0, ck_cnt = 0;

  intan_spi_top_module dut (
    .clk_ext        (clk_ext),
    .reset          (reset),
    .SPI_continuous (SPI_continuous),
    .SPI_start      (SPI_start),
    .max_timestep   (max_timestep),
    .clk            (clk),
    .clk_stable     (clk_stable),
    .SCLK           (SCLK),
    .CS             (CS),
    .MOSI           (MOSI),
    .state_counter  (state_counter),
    .channel        (channel),
    .timestamp      (timestamp),
    .instr_counter  (instr_counter),
    .instr          (instr)
  );

  always #10 clk_ext = ~clk_ext;

  function automatic logic [15:0] tb_cmd(input int c);
    logic [5:0] c6;
    c6 = c[5:0];
    if (c < 32) return {2'b00, c6, 8'h00};
    if (c == 32) return 16'hE800;
    if (c == 33) return 16'hE900;
    return 16'hEA00;
  endfunction

  // Pin monitor: shifts MOSI on each SCLK rise, closes a word when CS returns high.
  always @(posedge clk_ext) begin
    #1;
    if (CS) begin
      if (!prev_cs) begin
        obs_q.push_back(shreg);
        lo_q.push_back(lo_cnt);
        ck_q.push_back(ck_cnt);
        hi_cnt = 0;
      end
      hi_cnt++;
    end else begin
      if (prev_cs) begin
        hi_q.push_back(hi_cnt);
        lo_cnt = 0;
        ck_cnt = 0;
        shreg  = 16'd0;
      end
      lo_cnt++;
    end
    if (!prev_sclk && SCLK) begin
      shreg = {shreg[14:0], MOSI};
      ck_cnt++;
    end
    prev_cs   = CS;
    prev_sclk = SCLK;
  end

  task automatic clear_sb();
    exp_q.delete(); obs_q.delete(); lo_q.delete(); ck_q.delete(); hi_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; SPI_start = 1'b1; SPI_continuous = 1'b1; max_timestep = 32'd1;
    repeat (2) @(negedge clk_ext);
    n_checks++;
    if (clk_stable !== 1'b0 || CS !== 1'b1 || SCLK !== 1'b0 || MOSI !== 1'b0) begin
      n_fail++; $display("FAIL reset_pins: stable=%b CS=%b SCLK=%b MOSI=%b, want 0 1 0 0", clk_stable, CS, SCLK, MOSI);
    end
    n_checks++;
    if (state_counter !== 7'd0 || channel !== 6'd0 || timestamp !== 32'd0 || instr_counter !== 4'd0 || instr !== 16'd0) begin
      n_fail++; $display("FAIL reset_counters: sc=%0d ch=%0d ts=%0d ic=%0d instr=%h, want all 0", state_counter, channel, timestamp, instr_counter, instr);
    end
    @(negedge clk_ext);
    reset = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk_ext);
      n_checks++;
      if (clk_stable !== 1'b0 || CS !== 1'b1) begin
        n_fail++; $display("FAIL prelock_%0d: stable=%b CS=%b, want 0 1", i, clk_stable, CS);
      end
    end
    @(negedge clk_ext);
    n_checks++;
    if (clk_stable !== 1'b1 || CS !== 1'b1) begin
      n_fail++; $display("FAIL lock_rise: stable=%b CS=%b, want 1 1", clk_stable, CS);
    end
    @(negedge clk_ext);
    n_checks++;
    if (CS !== 1'b0 || state_counter !== 7'd0 || channel !== 6'd0 || timestamp !== 32'd0) begin
      n_fail++; $display("FAIL run_entry: CS=%b sc=%0d ch=%0d ts=%0d, want 0 0 0 0", CS, state_counter, channel, timestamp);
    end
    clear_sb();
  endtask

  task automatic test_frame();
    int got;
    logic [15:0] e, o;
    for (int i = 0; i < 36; i++) exp_q.push_back(tb_cmd(i % 35));
    got = 0;
    for (int c = 0; c < 36 * 80 + 100; c++) begin
      @(negedge clk_ext);
      n_checks++;
      if (instr !== tb_cmd(int'(channel))) begin
        n_fail++; $display("FAIL instr_ch%0d: got %h want %h", channel, instr, tb_cmd(int'(channel)));
      end
      n_checks++;
      if (state_counter < 7'd64) begin
        if (instr_counter !== state_counter[5:2] || CS !== 1'b0) begin
          n_fail++; $display("FAIL slot_active sc=%0d: ic=%0d CS=%b, want %0d 0", state_counter, instr_counter, CS, state_counter[5:2]);
        end
      end else if (instr_counter !== 4'd0 || CS !== 1'b1 || SCLK !== 1'b0 || MOSI !== 1'b0) begin
        n_fail++; $display("FAIL slot_gap sc=%0d: ic=%0d CS=%b SCLK=%b MOSI=%b, want 0 1 0 0", state_counter, instr_counter, CS, SCLK, MOSI);
      end
      if (obs_q.size() >= 36) begin got = 1; break; end
    end
    n_checks++;
    if (!got) begin
      n_fail++; $display("FAIL frame_timeout: words=%0d want 36", obs_q.size());
    end else begin
      for (int i = 0; i < 36; i++) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        n_checks++;
        if (o !== e) begin
          n_fail++; $display("FAIL word_slot%0d: got %h want %h", i % 35, o, e);
        end
        n_checks++;
        if (lo_q[i] != 64 || ck_q[i] != 16) begin
          n_fail++; $display("FAIL framing_slot%0d: cs_low=%0d sclk_rises=%0d, want 64 16", i % 35, lo_q[i], ck_q[i]);
        end
      end
      n_checks++;
      if (hi_q.size() < 35) begin
        n_fail++; $display("FAIL cs_high_count: gaps=%0d want >=35", hi_q.size());
      end else begin
        for (int i = 0; i < 35; i++) begin
          n_checks++;
          if (hi_q[i] != 16) begin
            n_fail++; $display("FAIL cs_high_gap%0d: got %0d want 16", i, hi_q[i]);
          end
        end
      end
    end
  endtask

  task automatic test_continuous();
    int ok;
    ok = 0;
    for (int c = 0; c < 3 * 2800; c++) begin
      @(negedge clk_ext);
      if (timestamp == 32'd3) begin ok = 1; break; end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL cont_ts3: ts=%0d want 3", timestamp); end
    ok = 0;
    for (int c = 0; c < 2900; c++) begin
      @(negedge clk_ext);
      if (channel == 6'd34) begin ok = 1; break; end
    end
    if (ok) begin
      ok = 0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk_ext);
        if (channel != 6'd34) begin ok = 1; break; end
      end
    end
    n_checks++;
    if (!ok || channel !== 6'd0 || timestamp !== 32'd4 || CS !== 1'b0 || state_counter !== 7'd0) begin
      n_fail++; $display("FAIL cont_wrap: ch=%0d ts=%0d CS=%b sc=%0d, want 0 4 0 0", channel, timestamp, CS, state_counter);
    end
  endtask

  task automatic relock();
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk_ext);
      if (i >= 15) begin
        n_checks++;
        if (clk_stable !== (i == 16)) begin
          n_fail++; $display("FAIL relock_%0d: stable=%b want %b", i, clk_stable, (i == 16));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int ok;
    ok = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk_ext);
      if (state_counter == 7'd40) begin ok = 1; break; end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL mid_wait: sc=%0d want 40", state_counter); end
    reset = 1'b1;
    @(negedge clk_ext);
    n_checks++;
    if (CS !== 1'b1 || SCLK !== 1'b0 || state_counter !== 7'd0 || channel !== 6'd0 || timestamp !== 32'd0 || clk_stable !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: CS=%b SCLK=%b sc=%0d ch=%0d ts=%0d stable=%b, want 1 0 0 0 0 0", CS, SCLK, state_counter, channel, timestamp, clk_stable);
    end
    reset = 1'b0; SPI_start = 1'b0; SPI_continuous = 1'b0; max_timestep = 32'd3;
    relock();
  endtask

  task automatic test_oneshot();
    int cyc, ok;
    logic [15:0] o;
    @(negedge clk_ext);
    SPI_start = 1'b1;
    clear_sb();
    for (int i = 0; i < 105; i++) exp_q.push_back(tb_cmd(i % 35));
    for (int t = 1; t <= 3; t++) begin
      cyc = 0; ok = 0;
      for (int c = 0; c < 3000; c++) begin
        @(negedge clk_ext);
        cyc++;
        if (timestamp == 32'(t)) begin ok = 1; break; end
      end
      n_checks++;
      if (!ok || cyc != ((t == 1) ? 2801 : 2800)) begin
        n_fail++; $display("FAIL ts_step%0d: cycles=%0d ts=%0d, want %0d %0d", t, cyc, timestamp, (t == 1) ? 2801 : 2800, t);
      end
    end
    n_checks++;
    if (CS !== 1'b1 || state_counter !== 7'd0 || channel !== 6'd0) begin
      n_fail++; $display("FAIL done_entry: CS=%b sc=%0d ch=%0d, want 1 0 0", CS, state_counter, channel);
    end
    repeat (10) @(negedge clk_ext);
    n_checks++;
    if (CS !== 1'b1 || timestamp !== 32'd3 || state_counter !== 7'd0) begin
      n_fail++; $display("FAIL done_hold: CS=%b ts=%0d sc=%0d, want 1 3 0", CS, timestamp, state_counter);
    end
    n_checks++;
    if (obs_q.size() != 105) begin
      n_fail++; $display("FAIL oneshot_words: got %0d want 105", obs_q.size());
    end else begin
      for (int i = 0; i < 105; i++) begin
        o = obs_q.pop_front();
        n_checks++;
        if (o !== exp_q[i] || ck_q[i] != 16) begin
          n_fail++; $display("FAIL oneshot_word%0d: got %h/%0d want %h/16", i, o, ck_q[i], exp_q[i]);
        end
      end
    end
    SPI_start = 1'b0;
    @(negedge clk_ext);
    SPI_start = 1'b1;
    @(negedge clk_ext);
    n_checks++;
    if (timestamp !== 32'd0 || CS !== 1'b0 || state_counter !== 7'd0) begin
      n_fail++; $display("FAIL retrigger: ts=%0d CS=%b sc=%0d, want 0 0 0", timestamp, CS, state_counter);
    end
  endtask

  task automatic test_zero_frames();
    int lows;
    reset = 1'b1; SPI_start = 1'b0; max_timestep = 32'd0;
    @(negedge clk_ext);
    reset = 1'b0;
    relock();
    SPI_start = 1'b1;
    lows = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk_ext);
      if (CS !== 1'b1 || SCLK !== 1'b0) lows++;
    end
    n_checks++;
    if (lows != 0 || state_counter !== 7'd0) begin
      n_fail++; $display("FAIL zero_frames: active_cycles=%0d sc=%0d, want 0 0", lows, state_counter);
    end
    SPI_start = 1'b0;
    @(negedge clk_ext);
    max_timestep = 32'd1;
    SPI_start = 1'b1;
    @(negedge clk_ext);
    n_checks++;
    if (CS !== 1'b0 || timestamp !== 32'd0) begin
      n_fail++; $display("FAIL zero_then_run: CS=%b ts=%0d, want 0 0", CS, timestamp);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_continuous();
    test_reset_mid();
    test_oneshot();
    test_zero_frames();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
